// File: rtl/ether_fcs_check.sv
// Ethernet FCS checker for the dibit stream coming out of the RMII receiver.
// Runs reflected CRC-32 over the whole frame and reports a one-cycle verdict at end of frame.
module ether_fcs_check #(
  parameter int MIN_BYTES = 64,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             done,
  output logic             fcs_ok,
  output logic             runt,
  output logic             misalign,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] MIN_U   = MIN_BYTES;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             done_q, done_d;
  logic             fcs_ok_q, fcs_ok_d;
  logic             runt_q, runt_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;

  // Two serial LSB-first steps per dibit: bit0 is the earlier wire bit.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 2; i++) begin
      fb = r[0] ^ d[i];
      r  = (r >> 1) ^ (fb ? POLY : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    dcnt_d       = dcnt_q;
    bcnt_d       = bcnt_q;
    done_d       = 1'b0;
    fcs_ok_d     = fcs_ok_q;
    runt_d       = runt_q;
    misalign_d   = misalign_q;
    byte_count_d = byte_count_q;

    case (state_q)
      // REPORT behaves like IDLE so a frame starting in the verdict cycle loses no dibit.
      IDLE, REPORT: begin
        if (axiiv) begin
          state_d = RUN;
          crc_d   = crc_dibit(32'hFFFFFFFF, axiid);
          dcnt_d  = 2'd1;
          bcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (axiiv) begin
          crc_d  = crc_dibit(crc_q, axiid);
          dcnt_d = 2'(dcnt_q + 2'd1);
          if (dcnt_q == 2'd3 && bcnt_q != '1) begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end else begin
          // Counters are final here; the verdict is registered so it is visible during REPORT.
          state_d      = REPORT;
          done_d       = 1'b1;
          misalign_d   = (dcnt_q != 2'd0);
          fcs_ok_d     = (crc_q == RESIDUE) && (dcnt_q == 2'd0);
          runt_d       = (32'(bcnt_q) < MIN_U);
          byte_count_d = bcnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      crc_q        <= 32'hFFFFFFFF;
      dcnt_q       <= 2'd0;
      bcnt_q       <= '0;
      done_q       <= 1'b0;
      fcs_ok_q     <= 1'b0;
      runt_q       <= 1'b0;
      misalign_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      dcnt_q       <= dcnt_d;
      bcnt_q       <= bcnt_d;
      done_q       <= done_d;
      fcs_ok_q     <= fcs_ok_d;
      runt_q       <= runt_d;
      misalign_q   <= misalign_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign done       = done_q;
  assign fcs_ok     = fcs_ok_q;
  assign runt       = runt_q;
  assign misalign   = misalign_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_ether_fcs_check.sv
// Scoreboard bench: two checkers (MIN_BYTES 8 and 64) share one dibit stream of directed frames.
module tb_ether_fcs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;

  logic        d8_done, d8_fcs_ok, d8_runt, d8_misalign;
  logic [10:0] d8_bc;
  logic        d64_done, d64_fcs_ok, d64_runt, d64_misalign;
  logic [10:0] d64_bc;

  ether_fcs_check #(.MIN_BYTES(8), .CNT_W(11)) u8 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .done(d8_done), .fcs_ok(d8_fcs_ok), .runt(d8_runt),
    .misalign(d8_misalign), .byte_count(d8_bc)
  );

  ether_fcs_check #(.MIN_BYTES(64), .CNT_W(11)) u64 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .done(d64_done), .fcs_ok(d64_fcs_ok), .runt(d64_runt),
    .misalign(d64_misalign), .byte_count(d64_bc)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic fcs;
    logic runt;
    logic mis;
    int   bc;
    int   cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q64[$];

  int cyc = 0;
  int last_cyc = 0;
  int total = 0;
  int bad = 0;
  int req_zero = 0, seen_zero = 0;
  int req_final = 0, seen_final = 0;
  int nframe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever either checker raises done.
  always @(negedge clk) begin
    exp_t e;
    if (rst && d8_done) begin
      if (q8.size() == 0) chk("dut8_unexpected_done", 1, 0);
      else begin
        e = q8.pop_front();
        $display("frame %0d dut8: fcs_ok=%0d runt=%0d misalign=%0d byte_count=%0d cyc=%0d",
                 nframe, d8_fcs_ok, d8_runt, d8_misalign, d8_bc, cyc);
        chk("dut8_fcs_ok", int'(d8_fcs_ok), int'(e.fcs));
        chk("dut8_runt", int'(d8_runt), int'(e.runt));
        chk("dut8_misalign", int'(d8_misalign), int'(e.mis));
        chk("dut8_byte_count", int'(d8_bc), e.bc);
        chk("dut8_done_cycle", cyc, e.cyc);
      end
    end
    if (rst && d64_done) begin
      if (q64.size() == 0) chk("dut64_unexpected_done", 1, 0);
      else begin
        e = q64.pop_front();
        $display("frame %0d dut64: fcs_ok=%0d runt=%0d misalign=%0d byte_count=%0d cyc=%0d",
                 nframe, d64_fcs_ok, d64_runt, d64_misalign, d64_bc, cyc);
        chk("dut64_fcs_ok", int'(d64_fcs_ok), int'(e.fcs));
        chk("dut64_runt", int'(d64_runt), int'(e.runt));
        chk("dut64_misalign", int'(d64_misalign), int'(e.mis));
        chk("dut64_byte_count", int'(d64_bc), e.bc);
        chk("dut64_done_cycle", cyc, e.cyc);
      end
      nframe++;
    end
    if (req_zero != seen_zero) begin
      seen_zero = req_zero;
      $display("reset check: done=%0d/%0d fcs_ok=%0d/%0d byte_count=%0d/%0d",
               d8_done, d64_done, d8_fcs_ok, d64_fcs_ok, d8_bc, d64_bc);
      chk("reset_done", int'(d8_done) + int'(d64_done), 0);
      chk("reset_fcs_ok", int'(d8_fcs_ok) + int'(d64_fcs_ok), 0);
      chk("reset_runt", int'(d8_runt) + int'(d64_runt), 0);
      chk("reset_misalign", int'(d8_misalign) + int'(d64_misalign), 0);
      chk("reset_byte_count", int'(d8_bc) + int'(d64_bc), 0);
    end
    if (req_final != seen_final) begin
      seen_final = req_final;
      chk("dut8_pending_verdicts", q8.size(), 0);
      chk("dut64_pending_verdicts", q64.size(), 0);
    end
  end

  task automatic drive_dibit(input logic [1:0] d);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = d;
    last_cyc = cyc;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) drive_dibit(b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      axiiv = 1'b0;
      axiid = 2'b00;
    end
  endtask

  // Verdict for the frame whose last dibit was just driven; done due 2 cycles later.
  task automatic expect_frame(input logic fcs, input int bc, input logic mis,
                              input logic runt8, input logic runt64);
    exp_t e;
    e.fcs = fcs; e.bc = bc; e.mis = mis; e.cyc = last_cyc + 2;
    e.runt = runt8;  q8.push_back(e);
    e.runt = runt64; q64.push_back(e);
  endtask

  logic [7:0] f_good [8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'hDF, 8'h44, 8'h21};
  logic [7:0] f_check[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                              8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  task automatic send_good;
    for (int i = 0; i < 8; i++) drive_byte(f_good[i]);
  endtask

  initial begin
    rst = 1'b0; axiiv = 1'b0; axiid = 2'b00;
    @(negedge clk); #1 req_zero++;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Good 8-byte frame: zeros plus FCS
    send_good();
    expect_frame(1'b1, 8, 1'b0, 1'b0, 1'b1);
    idle(3);

    // "123456789" with its FCS
    for (int i = 0; i < 13; i++) drive_byte(f_check[i]);
    expect_frame(1'b1, 13, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Corrupted last FCS byte
    for (int i = 0; i < 7; i++) drive_byte(f_good[i]);
    drive_byte(8'h20);
    expect_frame(1'b0, 8, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Good frame plus one stray dibit
    send_good();
    drive_dibit(2'b01);
    expect_frame(1'b0, 8, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Back-to-back: next frame starts in the verdict cycle
    send_good();
    expect_frame(1'b1, 8, 1'b0, 1'b0, 1'b1);
    idle(1);
    send_good();
    expect_frame(1'b1, 8, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Two-dibit runt
    drive_dibit(2'b11);
    drive_dibit(2'b10);
    expect_frame(1'b0, 0, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Reset after 10 bytes: no verdict for the aborted frame
    for (int i = 0; i < 10; i++) drive_byte(8'h55);
    @(negedge clk);
    #1 rst = 1'b0; axiiv = 1'b0; req_zero++;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    idle(2);
    send_good();
    expect_frame(1'b1, 8, 1'b0, 1'b0, 1'b1);
    idle(6);

    #1 req_final++;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
